// File: rtl/usb_packet_rx.sv
// usb_packet_rx: USB packet decoder behind a byte-wide transceiver.
// In: clk, reset (async, high), rx_active, rx_valid, rx_data[7:0],
//     rx_error. Out: pid/pid_valid, token_addr/token_endp/token_valid,
//     data/data_valid, packet_end/packet_error. Macro USB_RX_SOF_EN
//     adds frame_number[10:0]/sof_valid for CRC-correct SOF tokens.
module usb_packet_rx #(
  parameter int MAX_PAYLOAD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_error,
  output logic [3:0]  pid,
  output logic        pid_valid,
  output logic [6:0]  token_addr,
  output logic [3:0]  token_endp,
  output logic        token_valid,
  output logic [7:0]  data,
  output logic        data_valid,
`ifdef USB_RX_SOF_EN
  output logic [10:0] frame_number,
  output logic        sof_valid,
`endif
  output logic        packet_end,
  output logic        packet_error
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PID   = 3'd1;
  localparam logic [2:0] S_TOKEN = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_HSHK  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  localparam int CW = $clog2(MAX_PAYLOAD + 4) + 1;
  localparam logic [CW-1:0] LEN_MAX = CW'(MAX_PAYLOAD + 2);
  // counter sticks one above the legal maximum
  localparam logic [CW-1:0] LEN_SAT = CW'(MAX_PAYLOAD + 3);

  function automatic logic [4:0] crc5_byte(
    input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ 5'h05;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [2:0]    state_q, state_d, st_b;
  logic          act_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    crc5_q, crc5_d;
  logic [15:0]   crc16_q, crc16_d;
  logic          err_q, err_d, bad;
  logic [7:0]    buf1_q, buf1_d, buf2_q, buf2_d;
  logic [3:0]    pid_q, pid_d;
  logic          pv_q, pv_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    endp_q, endp_d;
  logic          tv_q, tv_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          pe_q, pe_d, perr_q, perr_d;
`ifdef USB_RX_SOF_EN
  logic [10:0]   frame_q, frame_d;
  logic          sof_q, sof_d;
`endif

  always_comb begin
    st_b    = state_q;
    cnt_d   = cnt_q;
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    err_d   = err_q;
    buf1_d  = buf1_q;
    buf2_d  = buf2_q;
    pid_d   = pid_q;
    pv_d    = 1'b0;
    addr_d  = addr_q;
    endp_d  = endp_q;
    tv_d    = 1'b0;
    data_d  = data_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    perr_d  = 1'b0;
    bad     = 1'b0;
`ifdef USB_RX_SOF_EN
    frame_d = frame_q;
    sof_d   = 1'b0;
`endif
    // byte handling first; end-of-packet below sees its result
    if (state_q != S_IDLE && rx_error) begin
      err_d = 1'b1;
      st_b  = S_DRAIN;
    end else if (rx_valid) begin
      case (state_q)
        S_PID: begin
          if (rx_data[7:4] == ~rx_data[3:0]) begin
            pid_d = rx_data[3:0];
            pv_d  = 1'b1;
            case (rx_data[3:0])
              4'h1, 4'h5, 4'h9, 4'hD: st_b = S_TOKEN;
              4'h3, 4'hB:             st_b = S_DATA;
              4'h2, 4'h6, 4'hA, 4'hE: st_b = S_HSHK;
              // DATA2/MDATA/PING/SPLIT/PRE/reserved unsupported
              default: begin
                st_b  = S_DRAIN;
                err_d = 1'b1;
              end
            endcase
          end else begin
            st_b  = S_DRAIN;
            err_d = 1'b1;
          end
        end
        S_TOKEN, S_DATA, S_HSHK: begin
          if (cnt_q != LEN_SAT) cnt_d = cnt_q + 1'b1;
          crc5_d  = crc5_byte(crc5_q, rx_data);
          crc16_d = crc16_byte(crc16_q, rx_data);
          buf1_d  = rx_data;
          buf2_d  = buf1_q;
          // two-byte lag keeps the CRC bytes off the output
          if (state_q == S_DATA && cnt_d >= CW'(3) &&
              cnt_d <= LEN_MAX) begin
            data_d = buf2_q;
            dv_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    state_d = st_b;
    if (state_q == S_IDLE) begin
      if (rx_active && !act_q) begin
        state_d = S_PID;
        cnt_d   = '0;
        crc5_d  = 5'h1F;
        crc16_d = 16'hFFFF;
        err_d   = 1'b0;
      end
    end else if (!rx_active) begin
      state_d = S_IDLE;
      pe_d    = 1'b1;
      case (st_b)
        S_PID:   bad = 1'b1;
        S_TOKEN: bad = (cnt_d != CW'(2)) ||
                       (crc5_d != 5'b01100);
        S_DATA:  bad = (cnt_d < CW'(2)) ||
                       (cnt_d > LEN_MAX) ||
                       (crc16_d != 16'h800D);
        S_HSHK:  bad = (cnt_d != '0);
        default: bad = 1'b0;
      endcase
      perr_d = err_d | bad;
      if (st_b == S_TOKEN && !(err_d | bad)) begin
        if (pid_d == 4'h5) begin
`ifdef USB_RX_SOF_EN
          frame_d = {buf1_d[2:0], buf2_d};
          sof_d   = 1'b1;
`endif
        end else begin
          tv_d   = 1'b1;
          addr_d = buf2_d[6:0];
          endp_d = {buf1_d[2:0], buf2_d[7]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      // treat the line as already active so a packet in flight
      // at release is not mistaken for a new one
      act_q   <= 1'b1;
      cnt_q   <= '0;
      crc5_q  <= '0;
      crc16_q <= '0;
      err_q   <= 1'b0;
      buf1_q  <= '0;
      buf2_q  <= '0;
      pid_q   <= '0;
      pv_q    <= 1'b0;
      addr_q  <= '0;
      endp_q  <= '0;
      tv_q    <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      perr_q  <= 1'b0;
`ifdef USB_RX_SOF_EN
      frame_q <= '0;
      sof_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      act_q   <= rx_active;
      cnt_q   <= cnt_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
      err_q   <= err_d;
      buf1_q  <= buf1_d;
      buf2_q  <= buf2_d;
      pid_q   <= pid_d;
      pv_q    <= pv_d;
      addr_q  <= addr_d;
      endp_q  <= endp_d;
      tv_q    <= tv_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      perr_q  <= perr_d;
`ifdef USB_RX_SOF_EN
      frame_q <= frame_d;
      sof_q   <= sof_d;
`endif
    end
  end

  assign pid          = pid_q;
  assign pid_valid    = pv_q;
  assign token_addr   = addr_q;
  assign token_endp   = endp_q;
  assign token_valid  = tv_q;
  assign data         = data_q;
  assign data_valid   = dv_q;
  assign packet_end   = pe_q;
  assign packet_error = perr_q;
`ifdef USB_RX_SOF_EN
  assign frame_number = frame_q;
  assign sof_valid    = sof_q;
`endif

endmodule

// File: tb/tb_usb_packet_rx.sv
// tb_usb_packet_rx: vector table, hand sequences and random
// packets checked against a packet-level reference model.
module tb_usb_packet_rx;
  localparam int MAXP = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_active, rx_valid, rx_error;
  logic [7:0] rx_data;
  logic [3:0] pid;
  logic       pid_valid;
  logic [6:0] token_addr;
  logic [3:0] token_endp;
  logic       token_valid;
  logic [7:0] data;
  logic       data_valid;
  logic       packet_end, packet_error;
`ifdef USB_RX_SOF_EN
  logic [10:0] frame_number;
  logic        sof_valid;
`endif

  usb_packet_rx #(.MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .reset(reset),
    .rx_active(rx_active), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_error(rx_error),
    .pid(pid), .pid_valid(pid_valid),
    .token_addr(token_addr), .token_endp(token_endp),
    .token_valid(token_valid),
    .data(data), .data_valid(data_valid),
`ifdef USB_RX_SOF_EN
    .frame_number(frame_number), .sof_valid(sof_valid),
`endif
    .packet_end(packet_end), .packet_error(packet_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int n_pv, n_tv, n_pe, n_perr;
  logic [3:0] m_pid;
  logic [6:0] m_addr;
  logic [3:0] m_endp;
  logic [7:0] m_data[$];

  int e_pv, e_tv, e_err;
  logic [3:0] e_pid;
  logic [6:0] e_addr;
  logic [3:0] e_endp;
  logic [7:0] e_data[$];

  logic [7:0] bs[$];

  typedef struct {
    int          n;
    logic [31:0] b;
    int          pv;
    logic [3:0]  pid;
    int          tv;
    int          err;
  } vec_t;

  vec_t vt[13];

  logic [3:0] tokp[4] = '{4'h1, 4'h9, 4'h5, 4'hD};
  logic [3:0] hskp[4] = '{4'h2, 4'h6, 4'hA, 4'hE};

  function automatic vec_t mk(int n, logic [31:0] b, int pv,
                              logic [3:0] p, int tv, int err);
    vec_t v;
    v.n = n; v.b = b; v.pv = pv;
    v.pid = p; v.tv = tv; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sample();
    if (pid_valid) begin n_pv++; m_pid = pid; end
    if (token_valid) begin
      n_tv++; m_addr = token_addr; m_endp = token_endp;
    end
    if (data_valid) m_data.push_back(data);
    if (packet_end) begin
      n_pe++;
      if (packet_error) n_perr++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      sample();
    end
  endtask

  task automatic clear();
    n_pv = 0; n_tv = 0; n_pe = 0; n_perr = 0;
    m_data.delete();
  endtask

  // token CRC field as it sits in byte2[7:3]
  function automatic logic [4:0] tok_crc(input logic [10:0] v);
    logic [4:0] c, f;
    c = 5'h1F;
    for (int i = 0; i < 11; i++)
      c = (c[4] ^ v[i]) ? ({c[3:0], 1'b0} ^ 5'h05)
                        : {c[3:0], 1'b0};
    c = ~c;
    for (int i = 0; i < 5; i++) f[i] = c[4-i];
    return f;
  endfunction

  // returns {second CRC byte, first CRC byte}
  function automatic logic [15:0] dat_crc(input logic [7:0] q[$],
                                          input int first,
                                          input int cnt);
    logic [15:0] c;
    logic [7:0] lb, hb;
    c = 16'hFFFF;
    for (int k = first; k < first + cnt; k++)
      for (int i = 0; i < 8; i++)
        c = (c[15] ^ q[k][i]) ? ({c[14:0], 1'b0} ^ 16'h8005)
                              : {c[14:0], 1'b0};
    c = ~c;
    for (int i = 0; i < 8; i++) begin
      lb[i] = c[15-i];
      hb[i] = c[7-i];
    end
    return {hb, lb};
  endfunction

  // returns {byte2, byte1}
  function automatic logic [15:0] tok_bytes(input logic [6:0] a,
                                            input logic [3:0] e);
    logic [10:0] v;
    v = {e, a};
    return {tok_crc(v), e[3:1], v[7:0]};
  endfunction

  task automatic model(input logic [7:0] q[$]);
    int L;
    logic [15:0] f16;
    e_pv = 0; e_tv = 0; e_err = 0;
    e_pid = '0; e_addr = '0; e_endp = '0;
    e_data.delete();
    if (q.size() == 0) begin e_err = 1; return; end
    if (q[0][7:4] != ~q[0][3:0]) begin e_err = 1; return; end
    e_pv = 1;
    e_pid = q[0][3:0];
    L = q.size() - 1;
    case (e_pid)
      4'h1, 4'h5, 4'h9, 4'hD: begin
        if (L != 2) e_err = 1;
        else if (tok_crc({q[2][2:0], q[1]}) != q[2][7:3])
          e_err = 1;
        else if (e_pid != 4'h5) begin
          e_tv = 1;
          e_addr = q[1][6:0];
          e_endp = {q[2][2:0], q[1][7]};
        end
      end
      4'h3, 4'hB: begin
        if (L < 2 || L > MAXP + 2) e_err = 1;
        else begin
          f16 = dat_crc(q, 1, L - 2);
          if ({q[L], q[L-1]} != f16) e_err = 1;
        end
        for (int i = 1; i <= L - 2 && i <= MAXP; i++)
          e_data.push_back(q[i]);
      end
      4'h2, 4'h6, 4'hA, 4'hE: if (L != 0) e_err = 1;
      default: e_err = 1;
    endcase
  endtask

  task automatic send_pkt(input logic [7:0] q[$],
                          input bit fall_same);
    rx_active = 1'b1;
    step(2);
    foreach (q[i]) begin
      step($urandom_range(0, 2));
      rx_data = q[i];
      rx_valid = 1'b1;
      if (fall_same && i == q.size() - 1) rx_active = 1'b0;
      step(1);
      rx_valid = 1'b0;
    end
    rx_active = 1'b0;
    step(3);
  endtask

  task automatic check_pkt(input string t);
    chk({t, ".pid_valid"}, n_pv, e_pv);
    if (e_pv != 0) chk({t, ".pid"}, m_pid, e_pid);
    chk({t, ".token_valid"}, n_tv, e_tv);
    if (e_tv != 0) begin
      chk({t, ".token_addr"}, m_addr, e_addr);
      chk({t, ".token_endp"}, m_endp, e_endp);
    end
    chk({t, ".ndata"}, m_data.size(), e_data.size());
    for (int i = 0; i < e_data.size() && i < m_data.size(); i++)
      chk($sformatf("%s.data%0d", t, i), m_data[i], e_data[i]);
    chk({t, ".packet_end"}, n_pe, 1);
    chk({t, ".packet_error"}, n_perr, e_err);
  endtask

  task automatic chk_reset_outs(input string t);
    chk({t, ".pid"}, pid, 0);
    chk({t, ".pid_valid"}, pid_valid, 0);
    chk({t, ".token_addr"}, token_addr, 0);
    chk({t, ".token_endp"}, token_endp, 0);
    chk({t, ".token_valid"}, token_valid, 0);
    chk({t, ".data"}, data, 0);
    chk({t, ".data_valid"}, data_valid, 0);
    chk({t, ".packet_end"}, packet_end, 0);
    chk({t, ".packet_error"}, packet_error, 0);
  endtask

  initial begin
    logic [15:0] t16;
    logic [3:0] p;
    int cls, len, r, bi;

    reset = 1'b1;
    rx_active = 1'b0; rx_valid = 1'b0;
    rx_error = 1'b0; rx_data = '0;
    clear();
    step(2);
    chk_reset_outs("reset");
    reset = 1'b0;
    step(2);

    vt[0]  = mk(3, 32'h2D0010_00, 1, 4'hD, 1, 0);
    vt[1]  = mk(3, 32'h2D0011_00, 1, 4'hD, 0, 1);
    vt[2]  = mk(3, 32'hC30000_00, 1, 4'h3, 0, 0);
    vt[3]  = mk(3, 32'hC30001_00, 1, 4'h3, 0, 1);
    vt[4]  = mk(1, 32'hD2000000, 1, 4'h2, 0, 0);
    vt[5]  = mk(1, 32'hD3000000, 0, 4'h0, 0, 1);
    vt[6]  = mk(3, 32'hA50010_00, 1, 4'h5, 0, 0);
    vt[7]  = mk(2, 32'hC3550000, 1, 4'h3, 0, 1);
    vt[8]  = mk(2, 32'h2D000000, 1, 4'hD, 0, 1);
    vt[9]  = mk(2, 32'hD2000000, 1, 4'h2, 0, 1);
    vt[10] = mk(1, 32'hF0000000, 1, 4'h0, 0, 1);
    vt[11] = mk(1, 32'h87000000, 1, 4'h7, 0, 1);
    vt[12] = mk(0, 32'h00000000, 0, 4'h0, 0, 1);

    for (int i = 0; i < 13; i++) begin
      bs.delete();
      for (int j = 0; j < vt[i].n; j++)
        bs.push_back(vt[i].b[31-8*j -: 8]);
      e_pv = vt[i].pv; e_pid = vt[i].pid;
      e_tv = vt[i].tv; e_err = vt[i].err;
      e_addr = '0; e_endp = '0;
      e_data.delete();
      clear();
      send_pkt(bs, (i % 2) == 1);
      check_pkt($sformatf("vec%0d", i));
    end

    // oversize DATA1: 11 payload bytes, only 8 delivered
    bs.delete();
    bs.push_back(8'h4B);
    for (int i = 0; i < 11; i++)
      bs.push_back(8'($urandom_range(0, 255)));
    t16 = dat_crc(bs, 1, 11);
    bs.push_back(t16[7:0]);
    bs.push_back(t16[15:8]);
    model(bs);
    chk("big.model_ndata", e_data.size(), 8);
    clear();
    send_pkt(bs, 1'b0);
    check_pkt("big");

    // same packet, reset after byte 4
    clear();
    rx_active = 1'b1;
    step(2);
    for (int i = 0; i < 4; i++) begin
      rx_data = bs[i]; rx_valid = 1'b1;
      step(1);
      rx_valid = 1'b0;
      step(1);
    end
    reset = 1'b1;
    #1;
    chk_reset_outs("rst_mid");
    step(2);
    reset = 1'b0;
    step(2);
    rx_active = 1'b0;
    step(3);
    chk("rst_mid.no_packet_end", n_pe, 0);
    bs.delete();
    t16 = tok_bytes(7'h2A, 4'h7);
    bs.push_back(8'h69);
    bs.push_back(t16[7:0]);
    bs.push_back(t16[15:8]);
    model(bs);
    clear();
    send_pkt(bs, 1'b0);
    check_pkt("after_rst");

    // rx_error mid-token
    clear();
    rx_active = 1'b1;
    step(2);
    rx_data = 8'h2D; rx_valid = 1'b1; step(1);
    rx_valid = 1'b0; rx_error = 1'b1; step(1);
    rx_error = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b1; step(1);
    rx_valid = 1'b0; rx_active = 1'b0;
    step(3);
    chk("rxerr.pid_valid", n_pv, 1);
    chk("rxerr.token_valid", n_tv, 0);
    chk("rxerr.packet_end", n_pe, 1);
    chk("rxerr.packet_error", n_perr, 1);

    // rx_active low for one cycle between two handshakes
    clear();
    rx_active = 1'b1; step(1);
    rx_data = 8'hD2; rx_valid = 1'b1; step(1);
    rx_valid = 1'b0; rx_active = 1'b0; step(1);
    chk("b2b.first_end", n_pe, 1);
    rx_active = 1'b1; step(1);
    rx_data = 8'h5A; rx_valid = 1'b1; step(1);
    rx_valid = 1'b0; rx_active = 1'b0;
    step(3);
    chk("b2b.pid_valid", n_pv, 2);
    chk("b2b.pid", m_pid, 4'hA);
    chk("b2b.packet_end", n_pe, 2);
    chk("b2b.packet_error", n_perr, 0);

    for (int k = 0; k < 200; k++) begin
      bs.delete();
      cls = $urandom_range(0, 9);
      if (cls < 4) begin
        p = tokp[$urandom_range(0, 3)];
        t16 = tok_bytes(7'($urandom_range(0, 127)),
                        4'($urandom_range(0, 15)));
        bs.push_back({~p, p});
        bs.push_back(t16[7:0]);
        bs.push_back(t16[15:8]);
      end else if (cls < 7) begin
        p = ($urandom_range(0, 1) == 1) ? 4'hB : 4'h3;
        len = $urandom_range(0, MAXP + 2);
        bs.push_back({~p, p});
        for (int i = 0; i < len; i++)
          bs.push_back(8'($urandom_range(0, 255)));
        t16 = dat_crc(bs, 1, len);
        bs.push_back(t16[7:0]);
        bs.push_back(t16[15:8]);
      end else if (cls < 9) begin
        p = hskp[$urandom_range(0, 3)];
        bs.push_back({~p, p});
      end else begin
        bs.push_back(8'($urandom_range(0, 255)));
      end
      r = $urandom_range(0, 7);
      if (r == 0) begin
        bi = $urandom_range(0, bs.size() - 1);
        bs[bi][$urandom_range(0, 7)] ^= 1'b1;
      end else if (r == 1) begin
        void'(bs.pop_back());
      end else if (r == 2) begin
        bs.push_back(8'($urandom_range(0, 255)));
      end
      model(bs);
      clear();
      send_pkt(bs, $urandom_range(0, 1) == 1);
      check_pkt($sformatf("rnd%0d", k));
      step($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
